// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: phase encoding, opcode
// constants, execute-length and state-code base helpers.
package seq_pkg;

  typedef enum logic [2:0] {
    PhIdle,
    PhFetch,
    PhExec,
    PhHalt,
    PhErr
  } phase_e;

  localparam int unsigned OP_HALT = 0;
  localparam int unsigned OP_LDR1 = 1;
  localparam int unsigned OP_LDR2 = 2;
  localparam int unsigned OP_STAC = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_MUL  = 5;

  // Truncated to the state width by the encoder.
  localparam logic [31:0] ST_ERR_ALL1 = '1;

  // Execute-phase length in cycles; 0 for opcodes that never execute.
  function automatic int unsigned exec_len(input int unsigned op);
    int unsigned len;
    len = 0;
    case (op)
      OP_LDR1, OP_LDR2, OP_STAC: len = 4;
      OP_ADD, OP_MUL:            len = 2;
      default:                   len = 0;
    endcase
    return len;
  endfunction

  // First flat state code of an opcode's execute phase. Execute codes are
  // packed back to back after the fetch codes, in opcode order.
  function automatic int unsigned exec_base(input int unsigned op,
                                            input int unsigned fetch_cyc);
    int unsigned base;
    base = fetch_cyc + 1;
    for (int unsigned k = OP_LDR1; k <= OP_MUL; k++) begin
      if (k < op) base = base + exec_len(k);
    end
    return base;
  endfunction

endpackage

// File: rtl/seq_state_enc.sv
// Flat state-code encoder: maps (phase, step, op) to the code consumed by the
// per-core control units. Purely combinational; also usable for reverse lookup.
// Ports:
//   phase  in  sequencer phase
//   step   in  step within the phase
//   op     in  latched opcode (meaningful in execute only)
//   state  out flat state code
module seq_state_enc import seq_pkg::*; #(
  parameter int unsigned FETCH_CYC = 6,
  parameter int unsigned OPC_W     = 6,
  parameter int unsigned STATE_W   = 6
) (
  input  phase_e             phase,
  input  logic [2:0]         step,
  input  logic [OPC_W-1:0]   op,
  output logic [STATE_W-1:0] state
);

  always_comb begin
    state = '0;
    case (phase)
      PhIdle:  state = '0;
      PhFetch: state = STATE_W'(32'd1 + 32'(step));
      PhExec:  state = STATE_W'(exec_base(32'(op), FETCH_CYC) + 32'(step));
      PhHalt:  state = STATE_W'(FETCH_CYC + 17);
      PhErr:   state = STATE_W'(ST_ERR_ALL1);
      default: state = '0;
    endcase
  end

endmodule

// File: rtl/seq_ctrl_fsm.sv
// Parametrised fetch/execute instruction sequencer with memory-wait stall,
// illegal-opcode handling and retired-instruction reporting.
// Build option: define SEQ_ILLEGAL_TRAP_EN to trap opcodes >5 into ERR;
// otherwise they retire as NOPs.
// Ports:
//   clock        in  rising-edge clock
//   reset_n      in  asynchronous active-low reset
//   start        in  run enable; low returns to idle on the next edge
//   wait_req     in  memory not ready; stalls fetch/execute
//   IR           in  instruction register, opcode in the top OPC_W bits
//   state        out flat state code
//   busy         out fetching or executing
//   retire       out one-cycle pulse per completed instruction
//   done         out halted
//   err          out trapped on an illegal opcode
//   retired_cnt  out completed-instruction count (wraps)
module seq_ctrl_fsm import seq_pkg::*; #(
  parameter int unsigned IR_W      = 16,
  parameter int unsigned OPC_W     = 6,
  parameter int unsigned FETCH_CYC = 6,
  parameter int unsigned STATE_W   = 6,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               wait_req,
  input  logic [IR_W-1:0]    IR,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               retire,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   retired_cnt
);

  if (OPC_W < 3) begin : gen_opc_w_check
    $error("seq_ctrl_fsm: OPC_W must be at least 3");
  end
  if ((FETCH_CYC + 17) >= (32'd1 << STATE_W)) begin : gen_state_w_check
    $error("seq_ctrl_fsm: STATE_W too narrow for the halt code");
  end
  if ((FETCH_CYC < 2) || (FETCH_CYC > 8)) begin : gen_fetch_cyc_check
    $error("seq_ctrl_fsm: FETCH_CYC must be in 2..8");
  end

  localparam logic [2:0] LastFetch = 3'(FETCH_CYC - 1);

  phase_e             phase_q, phase_d;
  logic [2:0]         step_q, step_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire_q, retire_d;

  logic [OPC_W-1:0]   opcode;
  int unsigned        op_val;
  logic               exec_last;

  // Only the opcode field of IR steers the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[IR_W-OPC_W-1:0];

  assign opcode = IR[IR_W-1 -: OPC_W];

  always_comb begin
    op_val    = 32'(opcode);
    exec_last = ((32'(step_q) + 32'd1) == exec_len(32'(op_q)));

    phase_d  = phase_q;
    step_d   = step_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    retire_d = 1'b0;

    if (!start) begin
      // Dropping start wins over everything, including a pending decode.
      phase_d = PhIdle;
      step_d  = '0;
    end else begin
      case (phase_q)
        PhIdle: begin
          phase_d = PhFetch;
          step_d  = '0;
        end
        PhFetch: begin
          if (!wait_req) begin
            if (step_q == LastFetch) begin
              step_d = '0;
              if (op_val == OP_HALT) begin
                phase_d = PhHalt;
              end else if (op_val <= OP_MUL) begin
                phase_d = PhExec;
                op_d    = opcode;
              end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                phase_d = PhErr;
`else
                phase_d  = PhFetch;
                retire_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
`endif
              end
            end else begin
              step_d = step_q + 3'd1;
            end
          end
        end
        PhExec: begin
          if (!wait_req) begin
            if (exec_last) begin
              phase_d  = PhFetch;
              step_d   = '0;
              retire_d = 1'b1;
              cnt_d    = cnt_q + CNT_W'(1);
            end else begin
              step_d = step_q + 3'd1;
            end
          end
        end
        PhHalt, PhErr: begin
          phase_d = phase_q;
        end
        default: begin
          phase_d = PhIdle;
          step_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= PhIdle;
      step_q   <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      retire_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      step_q   <= step_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      retire_q <= retire_d;
    end
  end

  seq_state_enc #(
    .FETCH_CYC (FETCH_CYC),
    .OPC_W     (OPC_W),
    .STATE_W   (STATE_W)
  ) u_state_enc (
    .phase (phase_q),
    .step  (step_q),
    .op    (op_q),
    .state (state)
  );

  assign busy        = (phase_q == PhFetch) || (phase_q == PhExec);
  assign done        = (phase_q == PhHalt);
  assign err         = (phase_q == PhErr);
  assign retire      = retire_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Bench for seq_ctrl_fsm: two instances (default and FETCH_CYC=3/CNT_W=4) share
// stimulus; each is compared every cycle against a cycle-count reference model.
module tb_seq_ctrl_fsm;

  localparam int MIdle  = 0;
  localparam int MFetch = 1;
  localparam int MExec  = 2;
  localparam int MHalt  = 3;
  localparam int MErr   = 4;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        wait_req;
  logic [15:0] ir;

  logic [5:0]  state0, state1;
  logic        busy0, busy1, retire0, retire1, done0, done1, err0, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int n_checks;
  int n_errors;

  // Reference model state, one slot per instance.
  int fc[2]  = '{6, 3};
  int cw[2]  = '{16, 4};
  int m_ph[2];
  int m_pos[2];   // fetch cycles already completed
  int m_left[2];  // execute cycles still to go
  int m_op[2];
  int m_cnt[2];
  int m_ret[2];

  seq_ctrl_fsm u_dut0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .wait_req    (wait_req),
    .IR          (ir),
    .state       (state0),
    .busy        (busy0),
    .retire      (retire0),
    .done        (done0),
    .err         (err0),
    .retired_cnt (cnt0)
  );

  seq_ctrl_fsm #(
    .FETCH_CYC (3),
    .CNT_W     (4)
  ) u_dut1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .wait_req    (wait_req),
    .IR          (ir),
    .state       (state1),
    .busy        (busy1),
    .retire      (retire1),
    .done        (done1),
    .err         (err1),
    .retired_cnt (cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int op_len(input int op);
    if (op >= 1 && op <= 3) return 4;
    if (op == 4 || op == 5) return 2;
    return 0;
  endfunction

  function automatic int exp_state(input int i);
    int base;
    case (m_ph[i])
      MFetch: return 1 + m_pos[i];
      MExec: begin
        base = fc[i] + 1;
        for (int k = 1; k < m_op[i]; k++) base += op_len(k);
        return base + op_len(m_op[i]) - m_left[i];
      end
      MHalt:   return fc[i] + 17;
      MErr:    return 63;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = MIdle; m_pos[i] = 0; m_left[i] = 0;
      m_op[i] = 0; m_cnt[i] = 0; m_ret[i] = 0;
    end
  endtask

  task automatic model_retire(input int i);
    m_ret[i] = 1;
    m_cnt[i] = (m_cnt[i] + 1) % (1 << cw[i]);
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_step(input int i);
    int op;
    op = int'(ir[15:10]);
    m_ret[i] = 0;
    if (!start) begin
      m_ph[i] = MIdle;
      m_pos[i] = 0;
    end else begin
      case (m_ph[i])
        MIdle: begin m_ph[i] = MFetch; m_pos[i] = 0; end
        MFetch: if (!wait_req) begin
          if (m_pos[i] + 1 == fc[i]) begin
            m_pos[i] = 0;
            if (op == 0) m_ph[i] = MHalt;
            else if (op <= 5) begin
              m_ph[i] = MExec; m_op[i] = op; m_left[i] = op_len(op);
            end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
              m_ph[i] = MErr;
`else
              model_retire(i);
`endif
            end
          end else m_pos[i]++;
        end
        MExec: if (!wait_req) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_ph[i] = MFetch; m_pos[i] = 0;
            model_retire(i);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state0", 32'(state0), exp_state(0));
    check_eq("busy0", 32'(busy0), (m_ph[0] == MFetch || m_ph[0] == MExec) ? 1 : 0);
    check_eq("done0", 32'(done0), (m_ph[0] == MHalt) ? 1 : 0);
    check_eq("err0", 32'(err0), (m_ph[0] == MErr) ? 1 : 0);
    check_eq("retire0", 32'(retire0), m_ret[0]);
    check_eq("cnt0", 32'(cnt0), m_cnt[0]);
    check_eq("state1", 32'(state1), exp_state(1));
    check_eq("busy1", 32'(busy1), (m_ph[1] == MFetch || m_ph[1] == MExec) ? 1 : 0);
    check_eq("done1", 32'(done1), (m_ph[1] == MHalt) ? 1 : 0);
    check_eq("err1", 32'(err1), (m_ph[1] == MErr) ? 1 : 0);
    check_eq("retire1", 32'(retire1), m_ret[1]);
    check_eq("cnt1", 32'(cnt1), m_cnt[1]);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    @(negedge clock);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic logic [15:0] make_ir(input int op);
    logic [5:0] opc;
    logic [9:0] low;
    opc = 6'(op);
    low = 10'($urandom);
    return {opc, low};
  endfunction

  initial begin
    int reached;
    int opc;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    wait_req = 1'b0;
    ir       = '0;
    model_reset();
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    run(2);

    // LDR1 back to back.
    start = 1'b1; ir = make_ir(1);
    run(12);

    // MUL with a 3-cycle memory stall mid-fetch.
    ir = make_ir(5);
    run(3);
    wait_req = 1'b1; run(3);
    wait_req = 1'b0; run(8);

    // HALT, then release.
    ir = make_ir(0);
    run(12);
    start = 1'b0; run(2);

    // Illegal opcode.
    start = 1'b1; ir = make_ir(9);
    run(12);
    start = 1'b0; run(1);

    // Asynchronous reset in the middle of ADD execute step 1.
    start = 1'b1; ir = make_ir(4);
    reached = 0;
    for (int k = 0; k < 40 && reached == 0; k++) begin
      tick();
      if (m_ph[0] == MExec && m_left[0] == 1 && m_cnt[0] > 0) reached = 1;
    end
    check_eq("reach_add_step1", 32'(reached), 1);
    #1 reset_n = 1'b0;
    #2 model_reset();
    compare_all();
    reset_n = 1'b1;

    // ADD stream long enough to wrap the 4-bit counter.
    run(150);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      start    = ($urandom_range(0, 39) != 0);
      wait_req = ($urandom_range(0, 3) == 0);
      opc      = $urandom_range(0, 19);
      if (opc >= 10) opc = 4;
      ir = make_ir(opc);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
